script_executor: RTL and testbench
==================================

Name: script_executor

Overview:
- Consumes the instruction stream from ScriptMem (drives its pc, reads its 16-bit script word).
- Turns each instruction into protocol bytes for the UART transmit path, or into waits and jumps that depend on game feedback.
- Sits between ScriptMem and the UART transmit path. It shares that path with the manual button/switch traffic; the top level selects which source is active.

Parameters:
- WAIT_UNIT, 10: ms_tick pulses per WAIT count (one count = 10 ms).
- MAX_TARGET, 20: highest legal target machine index; 0 is also illegal.

Ports:
- clock  in  1  uart 16x clock, same as UART/ScriptMem
- reset  in  1  synchronous, active-high
- script_mode  in  1  ScriptMem loading; aborts execution
- enable  in  1  run request (switch, already synchronised)
- script  in  16  instruction at pc
- pc  out  8  program counter to ScriptMem
- ms_tick  in  1  one-cycle pulse every 1 ms, in the clock domain
- feedback  in  4  {has_item_target, processing, has_item_hand, in_front}, already synchronised
- tx_bits  out  8  byte to transmit
- tx_valid  out  1  tx_bits valid
- tx_ready  in  1  transmitter accepted byte (dataIn_ready pulse)
- running  out  1  executing
- done  out  1  script ended normally
- error  out  1  illegal instruction or target

Behaviour:
- Instruction word fields:
  - [2:0] op
  - [4:3] reserved, ignored
  - [7:5] sub
  - [15:8] arg
- Transmit byte: tx_bits = {payload[5:0], chan[1:0]}. chan 01 = game state, 10 = operate, 11 = target.
- Opcodes:
  - 0 ACT: operate byte, payload {3'b000, sub}. sub 0, 6 or 7 -> ERROR.
  - 1 JIF: if feedback[sub[1:0]] == sub[2], pc <= arg; else pc+1.
  - 2 WAIT: wait arg*WAIT_UNIT ms_tick pulses, then pc+1. arg=0 -> no wait.
  - 3 WUNT: hold until feedback[sub[1:0]] == sub[2], then pc+1.
  - 4 GAME: sub=1 sends payload 1 (start), then pc+1. sub=2 sends payload 2 (end), then DONE. Other sub -> ERROR.
  - 5 TGT: target byte, payload arg[5:0]. arg==0 or arg>MAX_TARGET -> ERROR.
  - 6 GOTO: pc <= arg.
  - 7: ERROR.
- FSM states: IDLE, FETCH, DECODE, SEND, WAIT_T, WAIT_C, DONE, ERROR.
- Reset: state IDLE; pc=0, tx_bits=0, tx_valid=0, running=0, done=0, error=0; wait counter 0.
- IDLE -> FETCH when enable=1 and script_mode=0; pc=0.
- FETCH: one cycle for the memory read. DECODE samples script.
- Per-instruction latency:
  - JIF/GOTO: 2 cycles/instruction (FETCH+DECODE).
  - SEND: tx_valid=1 with tx_bits held stable until the cycle tx_ready=1. Next cycle tx_valid=0 and pc advances (or DONE), then FETCH.
  - tx_ready while tx_valid=0 is ignored.
- WAIT_T: counter increments on ms_tick only; exits the cycle the count reaches the target.
- WAIT_C: condition evaluated every cycle; exits the cycle it holds.
- pc arithmetic is 8-bit: pc+1 at 255 wraps to 0.
- DONE: done=1, running=0. ERROR: error=1, running=0, pc frozen at the faulting instruction. Both hold until enable=0, then IDLE and flags clear.
- running=1 in every state except IDLE, DONE and ERROR.
- Abort: script_mode=1, or enable=0, in any non-IDLE state.
  - Next cycle: IDLE, tx_valid=0, pc=0, wait counter cleared, flags cleared.
  - A byte in flight is dropped, not retried.
  - script_mode takes priority over enable.
- reset mid-operation behaves identically to abort, plus all outputs return to their reset values.

Decomposition:
- Shared package:
  - opcode constants OP_ACT..OP_ILL
  - channel constants CH_GAME, CH_OPER, CH_TGT
  - state encoding
  - feedback bit index constants
- Natural sub-module: script_wait_timer (ms_tick counter with load/clear/expired), reused by the manual path for auto-release timing.

Test Plan:
- ACT sub=3 at pc0, tx_ready after 5 cycles:
  - tx_bits=8'b000011_10 held for 5 cycles.
  - pc=1 the cycle after tx_ready.
- TGT arg=7: tx_bits=8'b000111_11.
- TGT arg=21: error=1, pc stays at the TGT address, tx_valid never asserts.
- WAIT arg=3, WAIT_UNIT=2 with sparse ms_tick: exits exactly on the 6th pulse; pc increments once.
- WUNT sub=3'b101 (feedback[1]==1): holds while feedback=4'b0000. Raise feedback[1]: pc advances 1 cycle later.
- JIF taken to arg=0x40: pc=0x40. GOTO at 255: pc=arg. Plain pc+1 at 255 wraps to 0.
- GAME end sub=2: byte 8'b000010_01 sent, then done=1.
- Abort: drop enable mid-SEND -> tx_valid=0 and pc=0 next cycle; re-enable restarts at pc0.
- script_mode pulse during WAIT_T -> IDLE, counter cleared.

Source files
------------

// File: rtl/script_executor_pkg.sv
// ============================================================================
// Package : script_executor_pkg
// Brief   : Opcodes, channels, states and feedback indices for the script executor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package script_executor_pkg;

    localparam logic [2:0] OP_ACT  = 3'd0;
    localparam logic [2:0] OP_JIF  = 3'd1;
    localparam logic [2:0] OP_WAIT = 3'd2;
    localparam logic [2:0] OP_WUNT = 3'd3;
    localparam logic [2:0] OP_GAME = 3'd4;
    localparam logic [2:0] OP_TGT  = 3'd5;
    localparam logic [2:0] OP_GOTO = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    localparam logic [1:0] CH_GAME = 2'b01;
    localparam logic [1:0] CH_OPER = 2'b10;
    localparam logic [1:0] CH_TGT  = 2'b11;

    localparam logic [5:0] GAME_START = 6'd1;
    localparam logic [5:0] GAME_END   = 6'd2;

    localparam int FB_IN_FRONT        = 0;
    localparam int FB_HAS_ITEM_HAND   = 1;
    localparam int FB_PROCESSING      = 2;
    localparam int FB_HAS_ITEM_TARGET = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_SEND   = 3'd3,
        S_WAIT_T = 3'd4,
        S_WAIT_C = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    function automatic logic [7:0] make_tx_byte(input logic [5:0] payload, input logic [1:0] chan);
        return {payload, chan};
    endfunction

    // sub[1:0] selects the feedback bit, sub[2] is the level it must equal
    function automatic logic fb_match(input logic [3:0] fb, input logic [2:0] sub);
        return fb[sub[1:0]] == sub[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/script_wait_timer.sv
// ============================================================================
// Module  : script_wait_timer
// Brief   : Counts ms_tick pulses against a loaded target; expired marks the reaching tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module script_wait_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_count_inc;

    assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    // Asserted combinationally so the owner can leave on the very tick that completes the wait
    assign expired     = tick && (w_count_inc == r_target);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count  <= '0;
            r_target <= '0;
        end else if (load) begin
            r_count  <= '0;
            r_target <= load_value;
        end else if (tick && (r_count != r_target)) begin
            r_count <= w_count_inc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/script_executor.sv
// ============================================================================
// Module  : script_executor
// Brief   : Fetches ScriptMem instructions and turns them into UART bytes, waits and jumps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module script_executor
    import script_executor_pkg::*;
#(
    parameter int WAIT_UNIT  = 10,
    parameter int MAX_TARGET = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        script_mode,
    input  logic        enable,
    input  logic [15:0] script,
    output logic [7:0]  pc,
    input  logic        ms_tick,
    input  logic [3:0]  feedback,
    output logic [7:0]  tx_bits,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        running,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] C_WAIT_UNIT  = 16'(WAIT_UNIT);
    localparam logic [7:0]  C_MAX_TARGET = 8'(MAX_TARGET);

    state_t      r_state, w_state_next;
    logic [7:0]  r_pc, w_pc_next;
    logic [7:0]  r_tx_bits, w_tx_bits_next;
    logic        r_tx_valid, w_tx_valid_next;
    logic        r_last, w_last_next;
    logic        w_tmr_load, w_tmr_clear, w_tmr_expired;

    logic [2:0]  w_op;
    logic [2:0]  w_sub;
    logic [7:0]  w_arg;
    logic [15:0] w_wait_target;
    logic        w_unused_rsvd;

    assign w_op          = script[2:0];
    assign w_sub         = script[7:5];
    assign w_arg         = script[15:8];
    assign w_unused_rsvd = ^script[4:3];
    assign w_wait_target = 16'(w_arg) * C_WAIT_UNIT;

    script_wait_timer #(
        .WIDTH (16)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_tmr_clear),
        .load       (w_tmr_load),
        .load_value (w_wait_target),
        .tick       (ms_tick),
        .expired    (w_tmr_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= 8'd0;
            r_tx_bits  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_tx_bits  <= w_tx_bits_next;
            r_tx_valid <= w_tx_valid_next;
            r_last     <= w_last_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_tx_bits_next  = r_tx_bits;
        w_tx_valid_next = r_tx_valid;
        w_last_next     = r_last;
        w_tmr_load      = 1'b0;
        w_tmr_clear     = 1'b0;

        // Abort wins over everything; an in-flight byte is simply dropped
        if ((r_state != S_IDLE) && (script_mode || !enable)) begin
            w_state_next    = S_IDLE;
            w_pc_next       = 8'd0;
            w_tx_valid_next = 1'b0;
            w_last_next     = 1'b0;
            w_tmr_clear     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && !script_mode) begin
                        w_state_next = S_FETCH;
                        w_pc_next    = 8'd0;
                    end
                end
                S_FETCH: w_state_next = S_DECODE;
                S_DECODE: begin
                    case (w_op)
                        OP_ACT: begin
                            if ((w_sub == 3'd0) || (w_sub >= 3'd6)) begin
                                w_state_next = S_ERROR;
                            end else begin
                                w_tx_bits_next  = make_tx_byte({3'b000, w_sub}, CH_OPER);
                                w_tx_valid_next = 1'b1;
                                w_last_next     = 1'b0;
                                w_state_next    = S_SEND;
                            end
                        end
                        OP_JIF: begin
                            w_pc_next    = fb_match(feedback, w_sub) ? w_arg : r_pc + 8'd1;
                            w_state_next = S_FETCH;
                        end
                        OP_WAIT: begin
                            if (w_arg == 8'd0) begin
                                w_pc_next    = r_pc + 8'd1;
                                w_state_next = S_FETCH;
                            end else begin
                                w_tmr_load   = 1'b1;
                                w_state_next = S_WAIT_T;
                            end
                        end
                        OP_WUNT: w_state_next = S_WAIT_C;
                        OP_GAME: begin
                            if (w_sub == 3'd1) begin
                                w_tx_bits_next  = make_tx_byte(GAME_START, CH_GAME);
                                w_tx_valid_next = 1'b1;
                                w_last_next     = 1'b0;
                                w_state_next    = S_SEND;
                            end else if (w_sub == 3'd2) begin
                                w_tx_bits_next  = make_tx_byte(GAME_END, CH_GAME);
                                w_tx_valid_next = 1'b1;
                                w_last_next     = 1'b1;
                                w_state_next    = S_SEND;
                            end else begin
                                w_state_next = S_ERROR;
                            end
                        end
                        OP_TGT: begin
                            if ((w_arg == 8'd0) || (w_arg > C_MAX_TARGET)) begin
                                w_state_next = S_ERROR;
                            end else begin
                                w_tx_bits_next  = make_tx_byte(w_arg[5:0], CH_TGT);
                                w_tx_valid_next = 1'b1;
                                w_last_next     = 1'b0;
                                w_state_next    = S_SEND;
                            end
                        end
                        OP_GOTO: begin
                            w_pc_next    = w_arg;
                            w_state_next = S_FETCH;
                        end
                        default: w_state_next = S_ERROR;
                    endcase
                end
                S_SEND: begin
                    if (tx_ready) begin
                        w_tx_valid_next = 1'b0;
                        if (r_last) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_pc_next    = r_pc + 8'd1;
                            w_state_next = S_FETCH;
                        end
                    end
                end
                S_WAIT_T: begin
                    if (w_tmr_expired) begin
                        w_pc_next    = r_pc + 8'd1;
                        w_tmr_clear  = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
                S_WAIT_C: begin
                    if (fb_match(feedback, w_sub)) begin
                        w_pc_next    = r_pc + 8'd1;
                        w_state_next = S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc       = r_pc;
    assign tx_bits  = r_tx_bits;
    assign tx_valid = r_tx_valid;
    assign running  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_script_executor.sv
// ============================================================================
// Module  : tb_script_executor
// Brief   : Directed bench for script_executor with a byte scoreboard on the UART side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_script_executor;

    logic        clock = 1'b0;
    logic        reset, script_mode, enable, ms_tick, tx_ready;
    logic [15:0] script;
    logic [7:0]  pc, tx_bits;
    logic [3:0]  feedback;
    logic        tx_valid, running, done, error;

    logic [15:0] mem [256];
    logic [7:0]  exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;
    assign script = mem[pc];

    script_executor #(
        .WAIT_UNIT  (2),
        .MAX_TARGET (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .script_mode (script_mode),
        .enable      (enable),
        .script      (script),
        .pc          (pc),
        .ms_tick     (ms_tick),
        .feedback    (feedback),
        .tx_bits     (tx_bits),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .running     (running),
        .done        (done),
        .error       (error)
    );

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] sub, input logic [7:0] arg);
        return {arg, sub, 2'b00, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tick_pulse(input int gap);
        step(gap);
        ms_tick = 1'b1;
        step(1);
        ms_tick = 1'b0;
    endtask

    // Drops enable so the DUT returns to IDLE, then refills memory with illegal words
    task automatic restart();
        enable   = 1'b0;
        tx_ready = 1'b0;
        feedback = 4'b0000;
        ms_tick  = 1'b0;
        step(1);
        for (int i = 0; i < 256; i++) mem[i] = ins(3'd7, 3'd0, 8'd0);
    endtask

    // Scoreboard monitor: bytes must stay stable while pending and match at handshake
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && tx_valid) begin
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_byte: got %0h, expected no byte", tx_bits);
                    end else begin
                        check("tx_byte", 32'(tx_bits), 32'(exp_q.pop_front()));
                    end
                end else if (exp_q.size() != 0) begin
                    check("tx_hold", 32'(tx_bits), 32'(exp_q[0]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] bad_ins [4];

    initial begin
        reset = 1'b1; script_mode = 1'b0; enable = 1'b0; ms_tick = 1'b0;
        tx_ready = 1'b0; feedback = 4'b0000;
        for (int i = 0; i < 256; i++) mem[i] = ins(3'd7, 3'd0, 8'd0);
        step(2);
        check("rst_pc", 32'(pc), 0);
        check("rst_tx_bits", 32'(tx_bits), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        reset = 1'b0;

        // ACT sub=3 held 5 cycles, then WUNT on feedback[1]==1
        restart();
        mem[0] = ins(3'd0, 3'd3, 8'd0);
        mem[1] = ins(3'd3, 3'b101, 8'd0);
        mem[2] = ins(3'd6, 3'd0, 8'd2);
        exp_q.push_back(8'b000011_10);
        enable = 1'b1;
        step(3);
        check("act_valid", 32'(tx_valid), 1);
        check("act_running", 32'(running), 1);
        step(4);
        check("act_still_valid", 32'(tx_valid), 1);
        check("act_pc_hold", 32'(pc), 0);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        check("act_valid_drop", 32'(tx_valid), 0);
        check("act_pc_adv", 32'(pc), 1);
        step(5);
        check("wunt_hold_pc", 32'(pc), 1);
        feedback = 4'b0010;
        step(1);
        check("wunt_exit_pc", 32'(pc), 2);
        feedback = 4'b0000;
        step(4);
        check("goto_self_pc", 32'(pc), 2);

        // TGT 7 accepted (ready held high early is ignored), TGT 21 faults
        restart();
        mem[0] = ins(3'd5, 3'd0, 8'd7);
        mem[1] = ins(3'd5, 3'd0, 8'd21);
        exp_q.push_back(8'b000111_11);
        enable = 1'b1;
        tx_ready = 1'b1;
        step(3);
        check("tgt_valid", 32'(tx_valid), 1);
        step(1);
        check("tgt_pc_adv", 32'(pc), 1);
        check("tgt_valid_drop", 32'(tx_valid), 0);
        step(2);
        check("tgt21_error", 32'(error), 1);
        check("tgt21_running", 32'(running), 0);
        check("tgt21_pc", 32'(pc), 1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("tgt21_no_valid", 32'(tx_valid), 0);
        end
        check("tgt21_error_held", 32'(error), 1);
        tx_ready = 1'b0;
        enable = 1'b0;
        step(1);
        check("err_clear", 32'(error), 0);
        check("err_clear_pc", 32'(pc), 0);

        // WAIT arg=3 with WAIT_UNIT=2: exits on the 6th sparse tick
        restart();
        mem[0] = ins(3'd2, 3'd0, 8'd3);
        mem[1] = ins(3'd3, 3'b100, 8'd0);
        enable = 1'b1;
        step(3);
        for (int k = 1; k <= 5; k++) begin
            tick_pulse(3);
            check("wait_pc_before", 32'(pc), 0);
        end
        tick_pulse(2);
        check("wait_pc_exit", 32'(pc), 1);
        step(6);
        check("wait_pc_once", 32'(pc), 1);

        // script_mode pulse in WAIT_T aborts; a fresh run needs the full 4 ticks
        restart();
        mem[0] = ins(3'd2, 3'd0, 8'd2);
        mem[1] = ins(3'd3, 3'b100, 8'd0);
        enable = 1'b1;
        step(3);
        tick_pulse(2);
        tick_pulse(2);
        check("sm_pc_before", 32'(pc), 0);
        script_mode = 1'b1;
        step(1);
        script_mode = 1'b0;
        check("sm_running", 32'(running), 0);
        check("sm_pc", 32'(pc), 0);
        step(3);
        for (int k = 1; k <= 3; k++) begin
            tick_pulse(2);
            check("sm_rerun_pc", 32'(pc), 0);
        end
        tick_pulse(2);
        check("sm_rerun_exit", 32'(pc), 1);

        // JIF taken, JIF not taken, GOTO 255, plain increment wrapping to 0
        restart();
        mem[0]     = ins(3'd1, 3'b000, 8'h40);
        mem[8'h40] = ins(3'd1, 3'b100, 8'h10);
        mem[8'h41] = ins(3'd6, 3'd0, 8'hFF);
        mem[8'hFF] = ins(3'd2, 3'd0, 8'd0);
        enable = 1'b1;
        step(3);
        check("jif_taken", 32'(pc), 32'h40);
        step(2);
        check("jif_not_taken", 32'(pc), 32'h41);
        step(2);
        check("goto_ff", 32'(pc), 32'hFF);
        step(2);
        check("wrap_to_0", 32'(pc), 0);
        step(2);
        check("loop_again", 32'(pc), 32'h40);

        restart();
        mem[0]     = ins(3'd6, 3'd0, 8'hFF);
        mem[8'hFF] = ins(3'd6, 3'd0, 8'h33);
        mem[8'h33] = ins(3'd3, 3'b100, 8'd0);
        enable = 1'b1;
        step(3);
        check("goto_to_ff", 32'(pc), 32'hFF);
        step(2);
        check("goto_at_ff", 32'(pc), 32'h33);
        step(4);
        check("goto_settle", 32'(pc), 32'h33);

        // GAME start, ACT 5, GAME end -> DONE
        restart();
        mem[0] = ins(3'd4, 3'd1, 8'd0);
        mem[1] = ins(3'd0, 3'd5, 8'd0);
        mem[2] = ins(3'd4, 3'd2, 8'd0);
        exp_q.push_back(8'b000001_01);
        exp_q.push_back(8'b000101_10);
        exp_q.push_back(8'b000010_01);
        enable = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) step(1);
        check("game_done", 32'(done), 1);
        check("game_running", 32'(running), 0);
        check("game_error", 32'(error), 0);
        check("game_pc", 32'(pc), 2);
        check("game_valid", 32'(tx_valid), 0);
        tx_ready = 1'b0;
        enable = 1'b0;
        step(1);
        check("done_clear", 32'(done), 0);

        // Illegal instructions fault at pc 0 without sending
        bad_ins[0] = ins(3'd0, 3'd0, 8'd0);
        bad_ins[1] = ins(3'd0, 3'd6, 8'd0);
        bad_ins[2] = ins(3'd4, 3'd3, 8'd0);
        bad_ins[3] = ins(3'd7, 3'd0, 8'd0);
        for (int b = 0; b < 4; b++) begin
            restart();
            mem[0] = bad_ins[b];
            enable = 1'b1;
            step(3);
            check("illegal_error", 32'(error), 1);
            check("illegal_pc", 32'(pc), 0);
            check("illegal_valid", 32'(tx_valid), 0);
        end

        // Drop enable mid-SEND: byte discarded; re-enable restarts at pc 0
        restart();
        mem[0] = ins(3'd0, 3'd1, 8'd0);
        mem[1] = ins(3'd3, 3'b100, 8'd0);
        enable = 1'b1;
        step(3);
        check("abort_valid_before", 32'(tx_valid), 1);
        step(2);
        enable = 1'b0;
        step(1);
        check("abort_valid", 32'(tx_valid), 0);
        check("abort_pc", 32'(pc), 0);
        check("abort_running", 32'(running), 0);
        exp_q.push_back(8'b000001_10);
        enable = 1'b1;
        tx_ready = 1'b1;
        step(4);
        check("reenable_pc", 32'(pc), 1);
        check("reenable_valid", 32'(tx_valid), 0);
        tx_ready = 1'b0;

        // Reset in the middle of a WUNT hold
        step(3);
        check("pre_reset_running", 32'(running), 1);
        reset = 1'b1;
        step(1);
        check("midrst_running", 32'(running), 0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_tx_bits", 32'(tx_bits), 0);
        check("midrst_valid", 32'(tx_valid), 0);
        enable = 1'b0;
        step(1);
        reset = 1'b0;
        step(2);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
